div_share_scheduler: RTL and testbench
======================================

# div_share_scheduler

Shares a single iterative unsigned fixed-point long divider among `N_REQ` requesters. A round-robin arbiter grants one request at a time. The granted operands are loaded into a bit-serial restoring divider core. The result, tagged with the requester ID, is held until the consumer accepts it. The block sits between several DSP filter stages that need occasional normalisation divides and the one divider the design can afford on the nano9k fabric.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `DATA_W`, 8, operand and quotient width (unsigned)
- `FRAC_W`, 4, fractional bits of the quotient; quotient = floor((dividend << FRAC_W) / divisor)
- `i_clk`  in  1  single system clock
- `i_reset_n`  in  1  reset, asynchronous assert, active-low
- `i_req_valid`  in  N_REQ  per-requester request valid
- `o_req_ready`  out  N_REQ  per-requester accept; one-hot or zero
- `i_dividend`  in  N_REQ*DATA_W  packed dividends, requester k at [k*DATA_W +: DATA_W]
- `i_divisor`  in  N_REQ*DATA_W  packed divisors, same packing
- `o_rsp_valid`  out  1  response valid
- `i_rsp_ready`  in  1  consumer accepts response
- `o_rsp_quotient`  out  DATA_W  quotient, Q(DATA_W-FRAC_W).FRAC_W
- `o_rsp_id`  out  clog2(N_REQ) (min 1)  requester that issued the request
- `o_rsp_div0`  out  1  divisor was zero
- `o_busy`  out  1  state != IDLE

## Operation
- FSM states and transitions:
  - IDLE: if any `i_req_valid`, go to RUN; if the latched divisor is zero, go to DONE instead.
  - RUN: stays for exactly `DATA_W+FRAC_W` cycles, then goes to DONE.
  - DONE: goes to IDLE when `i_rsp_ready` is high.
- Arbitration:
  - Round-robin, evaluated only in IDLE.
  - Search starts at `last_grant+1` and wraps at N_REQ.
  - `o_req_ready[k]` is high only in IDLE, and only for the winner k. It is combinational from `i_req_valid` and the state.
  - A request transfers on `valid && ready`. Operands and ID are latched that cycle, and `last_grant` updates to k.
- Requesters must hold `i_req_valid` and their operands until accepted. Dropping valid before acceptance is allowed; that request is simply not granted.
- Divider core:
  - Restoring long division of the (DATA_W+FRAC_W)-bit numerator `dividend << FRAC_W` by `divisor`.
  - One quotient bit per RUN cycle, MSB first.
  - The remainder register is DATA_W+1 bits.
- Result width: the raw quotient is DATA_W+FRAC_W bits. If any of its upper FRAC_W bits are set, this is overflow; handling is per Configuration.
- Divide-by-zero: RUN is skipped; `o_rsp_quotient` is all ones and `o_rsp_div0` is 1.
- Response outputs are registered and stay stable while `o_rsp_valid && !i_rsp_ready`. No new grant is issued until the response is accepted.

## Timing
- Reset values:
  - `o_rsp_valid` 0, `o_rsp_quotient` 0, `o_rsp_id` 0, `o_rsp_div0` 0, `o_busy` 0.
  - `o_req_ready` 0 while in reset.
  - `last_grant` = N_REQ-1, so requester 0 wins first.
- Latency, normal divide: request accepted in cycle T; `o_rsp_valid` rises in cycle T+1+DATA_W+FRAC_W (T+13 at the defaults).
- Latency, divide-by-zero: `o_rsp_valid` rises in cycle T+1.
- Back-to-back: if `i_rsp_ready` is high in the first DONE cycle, the next grant can happen in the cycle after. Peak throughput is one divide per DATA_W+FRAC_W+2 cycles.
- Reset mid-RUN or mid-DONE: everything returns to the reset values immediately. The in-flight request and its response are discarded, and no response is produced for them.
- Simultaneous valids in IDLE: exactly one grant, per the round-robin order.

## Configuration
- `DIV_SHARE_SATURATE_EN` defined:
  - On overflow, `o_rsp_quotient` = all ones.
  - An extra output `o_rsp_ovf` (1 bit, reset 0) reports overflow.
- `DIV_SHARE_SATURATE_EN` undefined:
  - On overflow, `o_rsp_quotient` = low DATA_W bits of the raw quotient (wrap).
  - `o_rsp_ovf` does not exist.
- Divide-by-zero behaviour is identical in both builds.

## Structure
- Package `div_share_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Function `id_w(n)` = max(1, clog2(n)).
  - Default parameter constants.
- Sub-module `div_share_core`:
  - Bit-serial restoring divider.
  - Ports: start, numerator, divisor, done, quotient.
  - Holds the iteration counter and remainder register.
- The top level owns the arbiter, FSM, operand/ID latches, and the response register.

## Test plan
All scenarios use DATA_W=8, FRAC_W=4, N_REQ=2.
- Requester 0 sends 6/4 -> after 13 cycles: quotient 0x18 (1.5), id 0, div0 0.
- Requester 1 sends 5/0 -> 1 cycle later: quotient 0xFF, div0 1, id 1.
- Requester 0 sends 200/1 -> with the macro: 0xFF and ovf 1. Without the macro: 0x80.
- Both requesters hold valid continuously, `i_rsp_ready`=1 -> grant IDs alternate 0,1,0,1 and each transfer handshake is one cycle.
- Hold `i_rsp_ready`=0 for 5 cycles in DONE -> response stable, `o_req_ready` stays 0; accepted on the 6th cycle, then IDLE.
- Pulse `i_reset_n` low at RUN cycle 5 -> outputs at reset values and no response issued; afterwards requester 0 wins even if requester 1 was last.

Source files
------------

// File: rtl/div_share_pkg.sv
// Shared constants, FSM encodings and helpers for the shared divider scheduler.
// The optional saturating build is selected by DIV_SHARE_SATURATE_EN (see div_share_scheduler).
package div_share_pkg;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_FRAC_W = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Width of a requester ID; never zero so a single requester still gets a 1-bit tag.
    function automatic int id_w(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/div_share_core.sv
// Bit-serial restoring divider: one quotient bit per cycle, MSB first, after a start pulse.
// `done` flags the final iteration; `quotient` then already includes the last bit.
module div_share_core #(
    parameter int DATA_W = 8,
    parameter int NUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  numerator,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [NUM_W-1:0]  quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   rem_q, rem_d, rem_shift;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [NUM_W-1:0]  quo_q, quo_d;
    logic              qbit;

    // The remainder stays below the divisor, so DATA_W+1 bits hold the shifted trial value.
    assign rem_shift = {rem_q[DATA_W-1:0], num_q[NUM_W-1]};
    assign qbit      = (rem_shift >= {1'b0, divisor});

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        num_d = num_q;
        quo_d = quo_q;
        if (start) begin
            cnt_d = CNT_W'(NUM_W);
            rem_d = '0;
            num_d = numerator;
            quo_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            rem_d = qbit ? (rem_shift - {1'b0, divisor}) : rem_shift;
            num_d = num_q << 1;
            quo_d = {quo_q[NUM_W-2:0], qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            num_q <= '0;
            quo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            num_q <= num_d;
            quo_q <= quo_d;
        end
    end

    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = {quo_q[NUM_W-2:0], qbit};

endmodule

// File: rtl/div_share_scheduler.sv
// Round-robin front end sharing one iterative fixed-point divider among N_REQ requesters.
// Define DIV_SHARE_SATURATE_EN to saturate overflowing quotients and add o_rsp_ovf.
module div_share_scheduler
    import div_share_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*DATA_W-1:0]   i_dividend,
    input  logic [N_REQ*DATA_W-1:0]   i_divisor,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_quotient,
    output logic [id_w(N_REQ)-1:0]    o_rsp_id,
    output logic                      o_rsp_div0,
    output logic                      o_busy
`ifdef DIV_SHARE_SATURATE_EN
    ,
    output logic                      o_rsp_ovf
`endif
);

    localparam int IdW   = id_w(N_REQ);
    localparam int NUM_W = DATA_W + FRAC_W;

    logic [1:0]        state_q, state_d;
    logic [IdW-1:0]    last_grant_q, last_grant_d;
    logic [IdW-1:0]    req_id_q, req_id_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_quot_q, rsp_quot_d;
    logic [IdW-1:0]    rsp_id_q, rsp_id_d;
    logic              rsp_div0_q, rsp_div0_d;

    logic [N_REQ-1:0]  grant;
    logic [IdW-1:0]    grant_id;
    int                idx;
    logic              accept;
    logic [DATA_W-1:0] sel_dividend, sel_divisor;
    logic              sel_div0;
    logic              core_done;
    logic [NUM_W-1:0]  core_quot;
    logic              raw_ovf;
    logic [DATA_W-1:0] result;

    // Search begins just past the last winner; grants only exist in IDLE and out of reset.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant_q) + i) % N_REQ;
            if (grant == '0 && i_req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IdW'(idx);
            end
        end
        if (state_q != StIdle || !i_reset_n) begin
            grant = '0;
        end
    end

    assign accept       = |grant;
    assign sel_dividend = i_dividend[int'(grant_id)*DATA_W +: DATA_W];
    assign sel_divisor  = i_divisor[int'(grant_id)*DATA_W +: DATA_W];
    assign sel_div0     = (sel_divisor == '0);
    assign raw_ovf      = |core_quot[NUM_W-1 -: FRAC_W];

`ifdef DIV_SHARE_SATURATE_EN
    logic rsp_ovf_q, rsp_ovf_d;
    assign result    = raw_ovf ? '1 : core_quot[DATA_W-1:0];
    assign o_rsp_ovf = rsp_ovf_q;
`else
    logic unused_ovf;
    assign result     = core_quot[DATA_W-1:0];
    assign unused_ovf = raw_ovf;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_id_d     = req_id_q;
        divisor_d    = divisor_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_quot_d   = rsp_quot_q;
        rsp_id_d     = rsp_id_q;
        rsp_div0_d   = rsp_div0_q;
`ifdef DIV_SHARE_SATURATE_EN
        rsp_ovf_d    = rsp_ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = grant_id;
                    req_id_d     = grant_id;
                    divisor_d    = sel_divisor;
                    if (sel_div0) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                        rsp_quot_d  = '1;
                        rsp_id_d    = grant_id;
                        rsp_div0_d  = 1'b1;
`ifdef DIV_SHARE_SATURATE_EN
                        rsp_ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (core_done) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    rsp_quot_d  = result;
                    rsp_id_d    = req_id_q;
                    rsp_div0_d  = 1'b0;
`ifdef DIV_SHARE_SATURATE_EN
                    rsp_ovf_d   = raw_ovf;
`endif
                end
            end
            StDone: begin
                if (i_rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(N_REQ - 1);
            req_id_q     <= '0;
            divisor_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_quot_q   <= '0;
            rsp_id_q     <= '0;
            rsp_div0_q   <= 1'b0;
`ifdef DIV_SHARE_SATURATE_EN
            rsp_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_id_q     <= req_id_d;
            divisor_q    <= divisor_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_quot_q   <= rsp_quot_d;
            rsp_id_q     <= rsp_id_d;
            rsp_div0_q   <= rsp_div0_d;
`ifdef DIV_SHARE_SATURATE_EN
            rsp_ovf_q    <= rsp_ovf_d;
`endif
        end
    end

    div_share_core #(
        .DATA_W (DATA_W),
        .NUM_W  (NUM_W)
    ) u_core (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .start     (accept && !sel_div0),
        .numerator ({sel_dividend, {FRAC_W{1'b0}}}),
        .divisor   (divisor_q),
        .done      (core_done),
        .quotient  (core_quot)
    );

    assign o_req_ready    = grant;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_quotient = rsp_quot_q;
    assign o_rsp_id       = rsp_id_q;
    assign o_rsp_div0     = rsp_div0_q;
    assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_div_share_scheduler.sv
// Scoreboard bench for div_share_scheduler (N_REQ=2, DATA_W=8, FRAC_W=4), both macro builds.
module tb_div_share_scheduler;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_q;
    logic        rsp_id;
    logic        rsp_div0;
    logic        busy;
`ifdef DIV_SHARE_SATURATE_EN
    logic        rsp_ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       id;
        logic       div0;
        logic       ovf;
    } exp_t;

    typedef struct {
        int k;
        int a;
        int b;
        int q_wrap;
        int q_sat;
        int ovf;
        int div0;
        int lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    div_share_scheduler #(
        .N_REQ  (2),
        .DATA_W (8),
        .FRAC_W (4)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_dividend     (dividend),
        .i_divisor      (divisor),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_quotient (rsp_q),
        .o_rsp_id       (rsp_id),
        .o_rsp_div0     (rsp_div0),
        .o_busy         (busy)
`ifdef DIV_SHARE_SATURATE_EN
        ,
        .o_rsp_ovf      (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int q, input int id, input int div0, input int ovf);
        exp_t e;
        e.q    = 8'(q);
        e.id   = 1'(id);
        e.div0 = 1'(div0);
        e.ovf  = 1'(ovf);
        return e;
    endfunction

    // Monitor: every accepted response must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id %0d q 0x%0h, want no response", rsp_id, rsp_q);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_quotient", int'(rsp_q), int'(mon_e.q));
                chk("rsp_id", int'(rsp_id), int'(mon_e.id));
                chk("rsp_div0", int'(rsp_div0), int'(mon_e.div0));
`ifdef DIV_SHARE_SATURATE_EN
                chk("rsp_ovf", int'(rsp_ovf), int'(mon_e.ovf));
`endif
            end
        end
    end

    // Returns at the negedge of the grant cycle, or after the wait budget expires.
    task automatic wait_grant();
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", int'(busy), 0);
    endtask

    task automatic do_req(input int k, input int a, input int b, input exp_t e, input int lat);
        int t;
        int n;
        @(posedge clk);
        #1;
        dividend[k*8 +: 8] = 8'(a);
        divisor[k*8 +: 8]  = 8'(b);
        req_valid[k]       = 1'b1;
        wait_grant();
        chk("grant_onehot", int'(req_ready), 1 << k);
        sb.push_back(e);
        t = cyc;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - t, lat);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_q"}, int'(rsp_q), 0);
        chk({tag, "_rsp_id"}, int'(rsp_id), 0);
        chk({tag, "_rsp_div0"}, int'(rsp_div0), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
`ifdef DIV_SHARE_SATURATE_EN
        chk({tag, "_rsp_ovf"}, int'(rsp_ovf), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tprev;
        int   qexp;
        logic seen;

        vecs = '{
            '{0,   6,   4, 'h18, 'h18, 0, 0, 13},
            '{1,   5,   0, 'hFF, 'hFF, 0, 1,  1},
            '{0, 200,   1, 'h80, 'hFF, 1, 0, 13},
            '{1,   0,   5, 'h00, 'h00, 0, 0, 13},
            '{0,  15,   1, 'hF0, 'hF0, 0, 0, 13},
            '{1,  16,   1, 'h00, 'hFF, 1, 0, 13},
            '{0, 255, 255, 'h10, 'h10, 0, 0, 13},
            '{1,   0,   0, 'hFF, 'hFF, 0, 1,  1}
        };

        req_valid = 2'b11;
        dividend  = '0;
        divisor   = '0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");

        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Directed single-requester vectors, including div-by-zero and overflow edges.
        foreach (vecs[i]) begin
`ifdef DIV_SHARE_SATURATE_EN
            qexp = vecs[i].q_sat;
`else
            qexp = vecs[i].q_wrap;
`endif
            do_req(vecs[i].k, vecs[i].a, vecs[i].b,
                   mk(qexp, vecs[i].k, vecs[i].div0, vecs[i].ovf), vecs[i].lat);
        end
        wait_idle();

        // Both requesters hold valid: grants alternate, one divide every 14 cycles.
        @(posedge clk);
        #1;
        dividend  = {8'd1, 8'd9};
        divisor   = {8'd3, 8'd3};
        req_valid = 2'b11;
        tprev     = 0;
        for (int n = 0; n < 4; n++) begin
            wait_grant();
            chk("rr_grant", int'(req_ready), (n % 2 == 0) ? 1 : 2);
            if (n > 0) chk("rr_interval", cyc - tprev, 14);
            tprev = cyc;
            sb.push_back((n % 2 == 0) ? mk('h30, 0, 0, 0) : mk('h05, 1, 0, 0));
            if (n == 3) begin
                @(posedge clk);
                #1;
                req_valid = 2'b00;
            end
            @(negedge clk);
            chk("rr_one_cycle", int'(req_ready), 0);
        end
        wait_idle();
        chk("rr_sb_empty", sb.size(), 0);

        // Consumer stalls for five DONE cycles while requester 1 waits.
        rsp_ready = 1'b0;
        do_req(0, 7, 2, mk('h38, 0, 0, 0), 13);
        @(posedge clk);
        #1;
        dividend[15:8] = 8'd3;
        divisor[15:8]  = 8'd3;
        req_valid[1]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(rsp_valid), 1);
            chk("stall_q", int'(rsp_q), 'h38);
            chk("stall_id", int'(rsp_id), 0);
            chk("stall_req_ready", int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept_req_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("post_stall_grant", int'(req_ready), 2);
        chk("post_stall_busy", int'(busy), 0);
        sb.push_back(mk('h10, 1, 0, 0));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Reset in RUN cycle 5 after requester 0 won: no response, requester 0 wins again.
        @(posedge clk);
        #1;
        dividend  = {8'd1, 8'd10};
        divisor   = {8'd1, 8'd4};
        req_valid = 2'b01;
        wait_grant();
        chk("abort_grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        chk_reset_state("midrun_reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        seen      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("abort_no_response", int'(seen), 0);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        wait_grant();
        chk("post_reset_rr", int'(req_ready), 1);
        sb.push_back(mk('h28, 0, 0, 0));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
